prime_collector: RTL and testbench
==================================

# prime_collector

Downstream stage of the prime sweep engine. It accepts one (number, prime-flag) result per handshake, buffers every prime in a FIFO for readout, and keeps running statistics: prime count, twin-prime pairs, largest gap and last prime. It sits between the sweep engine and the host readout/display logic, and it decouples the sweep rate from the readout rate.

## Interface
Parameters:
- DEPTH, 16, FIFO entries (power of two, 4..64)
- NW, 10, number width (covers 1..1000)

Ports:
- SysClk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset; one clock; all state cleared while low
- InValid  in  1  upstream result valid
- InReady  out  1  stage can accept a result
- InNumber  in  NW  number that was checked
- InPrime  in  1  1 = InNumber is prime
- InLast  in  1  final result of the sweep
- OutValid  out  1  FIFO head valid
- OutReady  in  1  consumer takes the head
- OutNumber  out  NW  FIFO head (a prime)
- PrimeCount  out  8  primes accepted, saturating at 255
- TwinCount  out  8  twin pairs (p, p+2), saturating at 255
- MaxGap  out  NW  largest difference between consecutive primes
- LastPrime  out  NW  most recent accepted prime, 0 if none
- Done  out  1  sticky: last result has been accepted and the FIFO is empty
- SeqError  out  1  sticky: a prime arrived that was not greater than LastPrime

## Operation
- Transfer on the input happens when InValid and InReady are both 1 on a rising edge. Transfer on the output happens when OutValid and OutReady are both 1.
- InReady = !fifo_full && !Done. It never depends on InValid or InPrime.
- Accepted non-prime: no FIFO write and no statistics change. InLast is still honoured.
- Accepted prime p with p > LastPrime:
  - push p into the FIFO
  - PrimeCount++
  - if LastPrime != 0: gap = p - LastPrime; MaxGap = max(MaxGap, gap); if gap == 2, TwinCount++
  - LastPrime = p
- Accepted prime p <= LastPrime: SeqError is set, the sample is discarded with no push and no statistics change, and the transfer still completes.
- Push and pop in the same cycle: the occupancy count stays the same. This is legal whenever the FIFO is neither full nor empty. When full, InReady is 0, so no push happens even if a pop occurs that cycle.
- Controller states:
  - RUN: normal operation.
  - DRAIN: entered on an accepted InLast. InReady is held at 0.
  - DONE: entered from DRAIN when the FIFO is empty. Done = 1. DONE is left only by reset.
- Counter widths:
  - Gap is computed in NW bits. It cannot wrap, because p > LastPrime is guaranteed by the sequence check.
  - Counters saturate; they never wrap.
- Reset values: InReady 0 while Reset is low, then 1. OutValid 0, OutNumber 0, PrimeCount 0, TwinCount 0, MaxGap 0, LastPrime 0, Done 0, SeqError 0. The FIFO is empty and the state is RUN.
- Reset asserted mid-operation: the FIFO contents are discarded immediately. No partial transfer is recorded.

## Timing
- All outputs are registered except InReady, which is combinational from the full flag and the state.
- A prime accepted at edge N appears at OutValid/OutNumber after edge N (0-cycle bypass is not used) if the FIFO was empty. The statistics outputs are updated after the same edge N.
- Pop at edge N: the next head, or OutValid = 0, is visible after edge N.
- Done rises one edge after the cycle in which the FIFO becomes empty in DRAIN, or one edge after InLast is accepted if the FIFO is already empty.
- Throughput: one input result per cycle and one output pop per cycle, sustained.

## Structure
- Shared package (prime_pkg): NW, the maximum sweep number of 1000, the count width of 8, and the state enum {RUN, DRAIN, DONE}. The sweep engine imports the same package.
- One sub-module, prime_fifo: a synchronous FIFO with DEPTH and WIDTH parameters, full/empty flags, and a pointer-plus-extra-bit occupancy scheme.
- The statistics update and the state machine live in the top level.

## Test plan
- Feed 1..30 with correct prime flags, with OutReady=1 throughout. Required: output sequence 2,3,5,7,11,13,17,19,23,29; PrimeCount=10; TwinCount=4 ((3,5), (5,7), (11,13), (17,19)); MaxGap=6; LastPrime=29. With InLast on 30: Done=1.
- Hold OutReady=0 and feed 17 primes with DEPTH=16. Required: InReady drops after the 16th prime, and the 17th is held upstream. Then take 1 output: the 17th is accepted next cycle, and the order is preserved.
- Push and pop in the same cycle at occupancy 5 for 10 cycles. Required: occupancy stays at 5 and the data order is preserved.
- Prime 7 followed by prime 5. Required: SeqError=1, PrimeCount and LastPrime unchanged (7), and 5 is not in the FIFO.
- Full 1..1000 sweep. Required: PrimeCount=168, TwinCount=35, MaxGap=20 (887→907), LastPrime=997, then Done.
- Assert Reset mid-sweep with 3 entries buffered. Required: all outputs return to their reset values at once, and after release the next prime is the first FIFO entry.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared definitions for the prime sweep engine and its collector stage.
package prime_pkg;

    // Largest number the sweep produces; the number width is derived from it.
    localparam int PRIME_MAX = 1000;
    localparam int PRIME_NW  = $clog2(PRIME_MAX + 1);
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO with a registered head word. Pointers carry one extra
// bit so full and empty are told apart without a separate counter.
module prime_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = wr_en && !full_q;
    assign pop_ok   = rd_en && valid_q;
    assign rd_data  = head_q;
    assign rd_valid = valid_q;
    assign full     = full_q;

    // Next pointers, flags and the head word that will be visible after the edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop_ok);
        valid_d  = (wr_ptr_d != rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        head_d   = '0;
        if (valid_d) begin
            // The slot being written this cycle is not in mem_q yet; forward it.
            if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer, flag and head registers; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

endmodule

// File: rtl/prime_collector.sv
// Collects sweep results: buffers primes for readout and keeps running
// prime statistics, then signals completion once the sweep has drained.
module prime_collector
    import prime_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NW    = PRIME_NW
) (
    input  logic             SysClk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [NW-1:0]    InNumber,
    input  logic             InPrime,
    input  logic             InLast,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [NW-1:0]    OutNumber,
    output logic [CNT_W-1:0] PrimeCount,
    output logic [CNT_W-1:0] TwinCount,
    output logic [NW-1:0]    MaxGap,
    output logic [NW-1:0]    LastPrime,
    output logic             Done,
    output logic             SeqError
);

    logic [NW-1:0]    last_prime_q, last_prime_d;
    logic [NW-1:0]    max_gap_q, max_gap_d;
    logic [CNT_W-1:0] prime_count_q, prime_count_d;
    logic [CNT_W-1:0] twin_count_q, twin_count_d;
    logic             seq_err_q, seq_err_d;
    logic             alive_q, alive_d;
    state_e           state_q;

    logic [NW-1:0]    gap;
    logic             in_fire;
    logic             prime_ok;
    logic             seq_bad;
    logic             fifo_full;

    // alive_q keeps InReady low while reset is held and until the first edge after.
    assign InReady  = alive_q && !fifo_full && (state_q == ST_RUN);
    assign in_fire  = InValid && InReady;
    assign prime_ok = in_fire && InPrime && (InNumber > last_prime_q);
    assign seq_bad  = in_fire && InPrime && (InNumber <= last_prime_q);
    // Only used when prime_ok holds, so the subtraction never wraps.
    assign gap      = InNumber - last_prime_q;

    assign PrimeCount = prime_count_q;
    assign TwinCount  = twin_count_q;
    assign MaxGap     = max_gap_q;
    assign LastPrime  = last_prime_q;
    assign SeqError   = seq_err_q;
    assign Done       = (state_q == ST_DONE);

    prime_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NW)
    ) u_fifo (
        .clk      (SysClk),
        .rst_n    (Reset),
        .wr_en    (prime_ok),
        .wr_data  (InNumber),
        .rd_en    (OutReady),
        .rd_data  (OutNumber),
        .rd_valid (OutValid),
        .full     (fifo_full)
    );

    // Statistics next-state: only an in-order prime changes them.
    always_comb begin
        alive_d       = 1'b1;
        prime_count_d = sat_inc(prime_count_q, prime_ok);
        twin_count_d  = twin_count_q;
        max_gap_d     = max_gap_q;
        last_prime_d  = last_prime_q;
        seq_err_d     = seq_err_q || seq_bad;
        if (prime_ok) begin
            last_prime_d = InNumber;
            if (last_prime_q != '0) begin
                if (gap > max_gap_q) begin
                    max_gap_d = gap;
                end
                twin_count_d = sat_inc(twin_count_q, gap == NW'(2));
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            alive_q       <= 1'b0;
            prime_count_q <= '0;
            twin_count_q  <= '0;
            max_gap_q     <= '0;
            last_prime_q  <= '0;
            seq_err_q     <= 1'b0;
        end else begin
            alive_q       <= alive_d;
            prime_count_q <= prime_count_d;
            twin_count_q  <= twin_count_d;
            max_gap_q     <= max_gap_d;
            last_prime_q  <= last_prime_d;
            seq_err_q     <= seq_err_d;
        end
    end

    // Controller: RUN until the last result is taken, DRAIN until the FIFO empties, then DONE.
    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (in_fire && InLast) state_q <= ST_DRAIN;
                ST_DRAIN: if (!OutValid)         state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_DONE;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_collector.sv
// Self-checking bench for prime_collector: a scoreboard queue is filled as
// results are accepted and drained as the DUT presents FIFO heads.
module tb_prime_collector;

    localparam int NW    = 10;
    localparam int DEPTH = 16;

    logic          SysClk = 1'b0;
    logic          Reset;
    logic          InValid, InReady, InPrime, InLast;
    logic [NW-1:0] InNumber;
    logic          OutValid, OutReady;
    logic [NW-1:0] OutNumber;
    logic [7:0]    PrimeCount, TwinCount;
    logic [NW-1:0] MaxGap, LastPrime;
    logic          Done, SeqError;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int out_log[$];
    int m_last, m_count, m_twin, m_gap;
    bit in_acc;

    always #5 SysClk = ~SysClk;

    prime_collector #(.DEPTH(DEPTH), .NW(NW)) dut (
        .SysClk     (SysClk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .InNumber   (InNumber),
        .InPrime    (InPrime),
        .InLast     (InLast),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutNumber  (OutNumber),
        .PrimeCount (PrimeCount),
        .TwinCount  (TwinCount),
        .MaxGap     (MaxGap),
        .LastPrime  (LastPrime),
        .Done       (Done),
        .SeqError   (SeqError)
    );

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int next_prime(int n);
        int k = n + 1;
        while (!is_prime(k)) k++;
        return k;
    endfunction

    // Reference behaviour for one accepted result.
    task automatic model_accept(int n, bit p);
        if (p && n > m_last) begin
            exp_q.push_back(n);
            if (m_count < 255) m_count++;
            if (m_last != 0) begin
                if (n - m_last > m_gap) m_gap = n - m_last;
                if (n - m_last == 2 && m_twin < 255) m_twin++;
            end
            m_last = n;
        end
    endtask

    // One clock: observe handshakes on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge SysClk);
        in_acc = Reset && InValid && InReady;
        if (in_acc) model_accept(int'(InNumber), InPrime);
        if (Reset && OutValid && OutReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got %0d required none", OutNumber);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (OutNumber !== NW'(e)) begin
                    errors++;
                    $display("FAIL pop_order got %0d required %0d", OutNumber, e);
                end
            end
            out_log.push_back(int'(OutNumber));
        end
        @(posedge SysClk);
        #1;
    endtask

    // Offer one result and hold it until it is accepted (bounded wait).
    task automatic send(input int n, input bit last, output int waited);
        InValid  = 1'b1;
        InNumber = NW'(n);
        InPrime  = is_prime(n);
        InLast   = last;
        waited   = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            waited++;
            if (in_acc) break;
        end
        checks++;
        if (!in_acc) begin
            errors++;
            $display("FAIL send_timeout number %0d not accepted in %0d cycles", n, waited);
        end
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        out_log.delete();
        m_last  = 0;
        m_count = 0;
        m_twin  = 0;
        m_gap   = 0;
    endtask

    task automatic apply_reset();
        Reset    = 1'b0;
        InValid  = 1'b0;
        InLast   = 1'b0;
        InPrime  = 1'b0;
        InNumber = '0;
        OutReady = 1'b0;
        clear_model();
        repeat (2) @(posedge SysClk);
        #1 Reset = 1'b1;
        @(posedge SysClk);
        #1;
    endtask

    task automatic test_reset();
        Reset    = 1'b0;
        InValid  = 1'b0;
        InLast   = 1'b0;
        InPrime  = 1'b0;
        InNumber = '0;
        OutReady = 1'b0;
        clear_model();
        @(posedge SysClk);
        #1;
        checks++;
        if (InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_inready got %b required 0", InReady);
        end
        checks++;
        if ({OutValid, OutNumber, PrimeCount, TwinCount, MaxGap, LastPrime, Done, SeqError} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b n=%0d pc=%0d tc=%0d mg=%0d lp=%0d d=%b se=%b required all 0",
                     OutValid, OutNumber, PrimeCount, TwinCount, MaxGap, LastPrime, Done, SeqError);
        end
        Reset = 1'b1;
        @(posedge SysClk);
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL release_inready got %b required 1", InReady);
        end
        $display("test_reset done");
    endtask

    task automatic test_sweep30();
        int w;
        int ref_out[10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        apply_reset();
        OutReady = 1'b1;
        for (int n = 1; n <= 30; n++) send(n, n == 30, w);
        for (int c = 0; c < 20 && Done !== 1'b1; c++) tick();
        checks++;
        if ({PrimeCount, TwinCount, MaxGap, LastPrime} !== {8'd10, 8'd4, 10'd6, 10'd29}) begin
            errors++;
            $display("FAIL sweep30_stats got pc=%0d tc=%0d mg=%0d lp=%0d required 10 4 6 29",
                     PrimeCount, TwinCount, MaxGap, LastPrime);
        end
        checks++;
        if (out_log.size() != 10) begin
            errors++;
            $display("FAIL sweep30_outcount got %0d required 10", out_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (out_log[i] != ref_out[i]) begin
                    errors++;
                    $display("FAIL sweep30_out[%0d] got %0d required %0d", i, out_log[i], ref_out[i]);
                end
            end
        end
        checks++;
        if (Done !== 1'b1 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL sweep30_done got done=%b inready=%b required 1 0", Done, InReady);
        end
        $display("test_sweep30 done outputs=%0d", out_log.size());
    endtask

    task automatic test_backpressure();
        int w;
        int p = 1;
        bit any_acc = 1'b0;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            p = next_prime(p);
            send(p, 1'b0, w);
        end
        checks++;
        if (InReady !== 1'b0) begin
            errors++;
            $display("FAIL full_inready got %b required 0", InReady);
        end
        p = next_prime(p);
        InValid  = 1'b1;
        InNumber = NW'(p);
        InPrime  = 1'b1;
        repeat (3) begin
            tick();
            any_acc |= in_acc;
        end
        checks++;
        if (any_acc || OutNumber !== NW'(2) || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold got acc=%b head=%0d valid=%b required 0 2 1", any_acc, OutNumber, OutValid);
        end
        OutReady = 1'b1;
        tick();
        any_acc |= in_acc;
        OutReady = 1'b0;
        tick();
        checks++;
        if (any_acc || !in_acc) begin
            errors++;
            $display("FAIL full_release got early=%b next=%b required 0 1", any_acc, in_acc);
        end
        InValid = 1'b0;
        checks++;
        if (PrimeCount !== 8'd17) begin
            errors++;
            $display("FAIL full_count got %0d required 17", PrimeCount);
        end
        OutReady = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
        checks++;
        if (exp_q.size() != 0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got left=%0d valid=%b required 0 0", exp_q.size(), OutValid);
        end
        $display("test_backpressure done outputs=%0d", out_log.size());
    endtask

    task automatic test_push_pop();
        int w;
        int p = 1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            p = next_prime(p);
            send(p, 1'b0, w);
        end
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            p = next_prime(p);
            send(p, 1'b0, w);
            checks++;
            if (w != 1) begin
                errors++;
                $display("FAIL pushpop_stall cycle %0d got wait=%0d required 1", i, w);
            end
        end
        out_log.delete();
        for (int c = 0; c < 20 && OutValid === 1'b1; c++) tick();
        checks++;
        if (out_log.size() != 5) begin
            errors++;
            $display("FAIL pushpop_occupancy got %0d required 5", out_log.size());
        end
        $display("test_push_pop done residual=%0d", out_log.size());
    endtask

    task automatic test_seq_error();
        int w;
        apply_reset();
        send(7, 1'b0, w);
        send(5, 1'b0, w);
        checks++;
        if (SeqError !== 1'b1 || PrimeCount !== 8'd1 || LastPrime !== NW'(7)) begin
            errors++;
            $display("FAIL seqerr_state got se=%b pc=%0d lp=%0d required 1 1 7", SeqError, PrimeCount, LastPrime);
        end
        OutReady = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_log.size() != 1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL seqerr_fifo got entries=%0d valid=%b required 1 0", out_log.size(), OutValid);
        end
        $display("test_seq_error done seqerror=%b", SeqError);
    endtask

    task automatic test_sweep1000();
        int w;
        apply_reset();
        for (int n = 1; n <= 1000; n++) begin
            OutReady = ($urandom_range(0, 3) != 0);
            send(n, n == 1000, w);
        end
        OutReady = 1'b1;
        for (int c = 0; c < 100 && Done !== 1'b1; c++) tick();
        checks++;
        if ({PrimeCount, TwinCount, MaxGap, LastPrime} !== {8'd168, 8'd35, 10'd20, 10'd997}) begin
            errors++;
            $display("FAIL sweep1000_stats got pc=%0d tc=%0d mg=%0d lp=%0d required 168 35 20 997",
                     PrimeCount, TwinCount, MaxGap, LastPrime);
        end
        checks++;
        if (Done !== 1'b1 || exp_q.size() != 0 || out_log.size() != 168) begin
            errors++;
            $display("FAIL sweep1000_done got done=%b left=%0d out=%0d required 1 0 168",
                     Done, exp_q.size(), out_log.size());
        end
        $display("test_sweep1000 done outputs=%0d", out_log.size());
    endtask

    task automatic test_reset_mid();
        int w;
        apply_reset();
        send(2, 1'b0, w);
        send(3, 1'b0, w);
        send(5, 1'b0, w);
        checks++;
        if (OutValid !== 1'b1 || PrimeCount !== 8'd3) begin
            errors++;
            $display("FAIL mid_prefill got valid=%b pc=%0d required 1 3", OutValid, PrimeCount);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({InReady, OutValid, OutNumber, PrimeCount, TwinCount, MaxGap, LastPrime, Done, SeqError} !== '0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b v=%b n=%0d pc=%0d tc=%0d mg=%0d lp=%0d required all 0",
                     InReady, OutValid, OutNumber, PrimeCount, TwinCount, MaxGap, LastPrime);
        end
        clear_model();
        repeat (2) @(posedge SysClk);
        #1 Reset = 1'b1;
        @(posedge SysClk);
        #1;
        OutReady = 1'b1;
        send(7, 1'b0, w);
        repeat (2) tick();
        checks++;
        if (out_log.size() != 1 || out_log[0] != 7) begin
            errors++;
            $display("FAIL mid_first got entries=%0d first=%0d required 1 7",
                     out_log.size(), out_log.size() > 0 ? out_log[0] : -1);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_sweep30();
        test_backpressure();
        test_push_pop();
        test_seq_error();
        test_sweep1000();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
